// File: rtl/marble_launcher.sv
// marble_launcher: marble source for the pulse-domain cell network.
// Holds a blue and a red hopper. On start, and later on each return-side
// lever trigger, it fires the next marble of the requested colour as a
// one-cycle pulse on o_left (blue) or o_right (red), LAUNCH_DELAY cycles
// after the request is accepted.
// Optional feature macro: MARBLE_LAUNCHER_RECYCLE_EN. When defined, a trigger
// accepted in FLIGHT returns the marble just flown to its hopper (saturating).
module marble_launcher #(
  parameter int BLUE_INIT    = 8,
  parameter int RED_INIT     = 8,
  parameter int CNT_W        = 4,
  parameter int LAUNCH_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             trig_left,
  input  logic             trig_right,
  input  logic             caught,
  input  logic             load,
  output logic             o_left,
  output logic             o_right,
  output logic [CNT_W-1:0] blue_count,
  output logic [CNT_W-1:0] red_count,
  output logic             busy,
  output logic             halted,
  output logic             empty,
  output logic             err_dual
);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, FLIGHT, HALT} state_t;

  localparam int               DLY_W    = (LAUNCH_DELAY > 1) ? $clog2(LAUNCH_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(LAUNCH_DELAY - 1);
  localparam logic [CNT_W-1:0] BLUE_RST = CNT_W'(BLUE_INIT);
  localparam logic [CNT_W-1:0] RED_RST  = CNT_W'(RED_INIT);

  // color: 0 = blue (left), 1 = red (right)
  state_t           state, state_nx;
  logic             color, color_nx;
  logic [DLY_W-1:0] dly, dly_nx;
  logic [CNT_W-1:0] blue_nx, red_nx;
  logic [CNT_W-1:0] blue_post, red_post;
  logic             empty_nx, err_nx;
  logic             want_red;
  logic [CNT_W-1:0] want_cnt;

  // Hopper counts as seen by a FLIGHT request, after any recycling of the
  // marble that was just fired.
`ifdef MARBLE_LAUNCHER_RECYCLE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  always_comb begin
    blue_post = blue_count;
    red_post  = red_count;
    if (!color && blue_count != CNT_MAX) blue_post = blue_count + 1'b1;
    if (color && red_count != CNT_MAX)   red_post  = red_count + 1'b1;
  end
`else
  always_comb begin
    blue_post = blue_count;
    red_post  = red_count;
  end
`endif

  // Left lever wins when both levers fire together.
  assign want_red = trig_right & ~trig_left;
  assign want_cnt = want_red ? red_post : blue_post;

  // Next-state and datapath updates; load overrides every state.
  always_comb begin
    state_nx = state;
    color_nx = color;
    dly_nx   = dly;
    blue_nx  = blue_count;
    red_nx   = red_count;
    empty_nx = empty;
    err_nx   = err_dual;
    if (load) begin
      state_nx = IDLE;
      color_nx = 1'b0;
      dly_nx   = '0;
      blue_nx  = BLUE_RST;
      red_nx   = RED_RST;
      empty_nx = 1'b0;
      err_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (blue_count != '0) begin
              state_nx = ARM;
              color_nx = 1'b0;
              dly_nx   = DLY_LOAD;
            end else begin
              state_nx = HALT;
              empty_nx = 1'b1;
            end
          end
        end
        ARM: begin
          if (dly == '0) state_nx = FIRE;
          else           dly_nx   = dly - 1'b1;
        end
        FIRE: begin
          // Only reachable with a non-zero count, so this never wraps.
          if (color) red_nx  = red_count - 1'b1;
          else       blue_nx = blue_count - 1'b1;
          state_nx = FLIGHT;
        end
        FLIGHT: begin
          if (caught) begin
            state_nx = HALT;
          end else if (trig_left || trig_right) begin
            blue_nx = blue_post;
            red_nx  = red_post;
            if (trig_left && trig_right) err_nx = 1'b1;
            if (want_cnt != '0) begin
              state_nx = ARM;
              color_nx = want_red;
              dly_nx   = DLY_LOAD;
            end else begin
              state_nx = HALT;
              empty_nx = 1'b1;
            end
          end
        end
        HALT:    state_nx = HALT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      color      <= 1'b0;
      dly        <= '0;
      blue_count <= BLUE_RST;
      red_count  <= RED_RST;
      empty      <= 1'b0;
      err_dual   <= 1'b0;
    end else begin
      state      <= state_nx;
      color      <= color_nx;
      dly        <= dly_nx;
      blue_count <= blue_nx;
      red_count  <= red_nx;
      empty      <= empty_nx;
      err_dual   <= err_nx;
    end
  end

  // Pulses and status are decodes of the registered state.
  assign o_left  = (state == FIRE) && !color;
  assign o_right = (state == FIRE) && color;
  assign busy    = (state == ARM) || (state == FIRE) || (state == FLIGHT);
  assign halted  = (state == HALT);

endmodule

// File: tb/tb_marble_launcher.sv
// Directed bench for marble_launcher: default instance (8/8 hoppers) and a
// second instance with a single blue marble for the empty/recycle cases.
module tb_marble_launcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic start = 0, trig_left = 0, trig_right = 0, caught = 0, load = 0;
  logic o_left, o_right, busy, halted, empty, err_dual;
  logic [3:0] blue_count, red_count;

  // single-blue-marble instance
  logic b_start = 0, b_trig_left = 0, b_trig_right = 0, b_caught = 0, b_load = 0;
  logic b_o_left, b_o_right, b_busy, b_halted, b_empty, b_err_dual;
  logic [3:0] b_blue_count, b_red_count;

  int total = 0;
  int bad   = 0;
  int pulses;

  marble_launcher dut (
    .clk(clk), .rst(rst), .start(start), .trig_left(trig_left),
    .trig_right(trig_right), .caught(caught), .load(load),
    .o_left(o_left), .o_right(o_right), .blue_count(blue_count),
    .red_count(red_count), .busy(busy), .halted(halted),
    .empty(empty), .err_dual(err_dual)
  );

  marble_launcher #(.BLUE_INIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(b_start), .trig_left(b_trig_left),
    .trig_right(b_trig_right), .caught(b_caught), .load(b_load),
    .o_left(b_o_left), .o_right(b_o_right), .blue_count(b_blue_count),
    .red_count(b_red_count), .busy(b_busy), .halted(b_halted),
    .empty(b_empty), .err_dual(b_err_dual)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // watch n cycles and count any marble pulse on the default instance
  task automatic watch(input int n);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (o_left || o_right) pulses++;
    end
  endtask

  initial begin
    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blue", blue_count, 8);
    chk("rst_red", red_count, 8);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", {empty, err_dual, o_left, o_right}, 0);
    rst = 1'b0;
    tick();

    // ---- start: pulse two edges after the accepting edge
    start = 1; tick(); start = 0;       // accepted
    chk("st_busy", busy, 1);
    tick();
    chk("st_left_early", o_left, 0);
    tick();
    chk("st_left", o_left, 1);
    chk("st_right_quiet", o_right, 0);
    tick();
    chk("st_left_width", o_left, 0);
    chk("st_blue", blue_count, 7);
    chk("st_flight_busy", busy, 1);

    // ---- trig_right in FLIGHT
    trig_right = 1; tick(); trig_right = 0;
    tick();
    chk("tr_right_early", o_right, 0);
    tick();
    chk("tr_right", o_right, 1);
    chk("tr_left_quiet", o_left, 0);
    tick();
    chk("tr_right_width", o_right, 0);
    chk("tr_red", red_count, 7);

    // ---- both levers: left wins, err_dual sticky
    trig_left = 1; trig_right = 1; tick(); trig_left = 0; trig_right = 0;
    chk("dual_err", err_dual, 1);
    tick(); tick();
    chk("dual_left", o_left, 1);
    chk("dual_right_quiet", o_right, 0);
    tick();
    chk("dual_blue", blue_count, 6);
    chk("dual_red", red_count, 7);

    // ---- caught beats trig_left
    caught = 1; trig_left = 1; tick(); caught = 0; trig_left = 0;
    chk("cau_halted", halted, 1);
    chk("cau_busy", busy, 0);
    watch(4);
    chk("cau_no_pulse", pulses, 0);
    start = 1; tick(); start = 0;
    watch(4);
    chk("halt_start_ign", pulses, 0);
    chk("halt_hold", halted, 1);
    chk("halt_blue", blue_count, 6);

    // ---- load from HALT
    load = 1; tick(); load = 0;
    chk("ld_halted", halted, 0);
    chk("ld_counts", {blue_count, red_count}, 8'h88);
    chk("ld_flags", {empty, err_dual, busy}, 0);

    // ---- load cancels a marble in ARM
    start = 1; tick(); start = 0;
    load = 1; tick(); load = 0;
    chk("ldarm_busy", busy, 0);
    watch(4);
    chk("ldarm_no_pulse", pulses, 0);
    chk("ldarm_blue", blue_count, 8);

    // ---- rst mid-ARM
    start = 1; tick(); start = 0;
    rst = 1; #1;
    chk("rstarm_busy", busy, 0);
    tick(); rst = 0;
    watch(4);
    chk("rstarm_no_pulse", pulses, 0);
    chk("rstarm_counts", {blue_count, red_count}, 8'h88);

    // ---- single blue marble: empty on second blue request
    b_start = 1; tick(); b_start = 0;
    tick(); tick();
    chk("one_left", b_o_left, 1);
    tick();
    chk("one_blue0", b_blue_count, 0);
    b_trig_left = 1; tick(); b_trig_left = 0;
`ifdef MARBLE_LAUNCHER_RECYCLE_EN
    for (int r = 0; r < 3; r++) begin
      chk("rc_blue1", b_blue_count, 1);
      chk("rc_busy", {b_busy, b_halted}, 2'b10);
      tick(); tick();
      chk("rc_left", b_o_left, 1);
      tick();
      chk("rc_blue0", b_blue_count, 0);
      b_trig_left = 1; tick(); b_trig_left = 0;
    end
`else
    chk("one_halted", b_halted, 1);
    chk("one_empty", b_empty, 1);
    chk("one_blue_hold", b_blue_count, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b_o_left || b_o_right) pulses++;
    end
    chk("one_no_pulse", pulses, 0);
    b_load = 1; tick(); b_load = 0;
    chk("one_ld_halted", b_halted, 0);
    chk("one_ld_blue", b_blue_count, 1);
    chk("one_ld_flags", {b_empty, b_err_dual, b_busy}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
